// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset/enable levels, NOP encoding.
// Imported by instr_fetch and fetch_fifo.
package instr_fetch_pkg;

  localparam int unsigned INSTR_ADDR_W = 32;            // InstrAddrBus width
  localparam int unsigned INSTR_W      = 32;            // InstrBus width

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;

  // addi x0, x0, 0 -- shown on the decode port whenever the buffer is empty
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: synchronous FIFO holding {address, instruction} pairs for decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push while full.
// Ports: i_clk/i_reset (sync, active-high), i_push/i_push_dat, i_pop, i_flush,
//        o_head_dat, o_count (0..DEPTH), o_full, o_empty.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head_dat,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Occupancy lives in its own register so full and empty are unambiguous
  // even when the pointers coincide.
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two makes
  // the increment wrap modulo DEPTH for free.
  always_ff @(posedge i_clk) begin
    if (i_reset == RST_ENABLE || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: the head is only consumed when o_count is nonzero.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush && i_reset != RST_ENABLE) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Purpose: issue ROM reads for PC addresses and queue {addr, instr} for decode.
// Latency: issue in cycle N, ROM word captured end of N+1, valid to decode in N+2.
// Backpressure: holds the PC once buffered + in-flight (net of this cycle's pop) fills DEPTH.
// Ports: clk_i_IF, reset_i_IF (sync, active-high), PC side (pc_addr_i_IF,
//        chip_enable_i_IF, pc_hold_o_IF), ROM side (rom_ce_o_IF, rom_addr_o_IF,
//        rom_data_i_IF), flush_i_IF, decode side (inst_valid_o_IF, inst_o_IF,
//        inst_addr_o_IF, inst_ready_i_IF).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = INSTR_ADDR_W,
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic              clk_i_IF,
  input  logic              reset_i_IF,
  input  logic [ADDR_W-1:0] pc_addr_i_IF,
  input  logic              chip_enable_i_IF,
  output logic              pc_hold_o_IF,
  output logic              rom_ce_o_IF,
  output logic [ADDR_W-1:0] rom_addr_o_IF,
  input  logic [DATA_W-1:0] rom_data_i_IF,
  input  logic              flush_i_IF,
  output logic              inst_valid_o_IF,
  output logic [DATA_W-1:0] inst_o_IF,
  output logic [ADDR_W-1:0] inst_addr_o_IF,
  input  logic              inst_ready_i_IF
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic              r_req_v;    // a ROM read was issued last cycle
  logic [ADDR_W-1:0] r_req_pc;   // address of that read

  logic              w_reset;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_hold;
  logic [CNT_W:0]    w_occ;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic [ENT_W-1:0]  w_head;

  assign w_reset = (reset_i_IF == RST_ENABLE);

  // Outputs are forced to their idle values while reset is high, even before
  // the synchronous clear of the FIFO has taken effect.
  assign w_valid = ~w_reset & ~w_empty;
  assign w_pop   = w_valid & inst_ready_i_IF;

  // Slots that will be committed after this edge: entries kept plus the read
  // whose data lands next cycle. Counting this cycle's pop lets a full FIFO
  // that is draining keep streaming; the ready->hold path is deliberate.
  assign w_occ  = {1'b0, w_count} - (CNT_W+1)'(w_pop) + (CNT_W+1)'(r_req_v);
  assign w_hold = ~w_reset & (w_occ >= (CNT_W+1)'(DEPTH));

  assign w_issue = (chip_enable_i_IF == CHIP_ENABLE) & ~w_hold & ~flush_i_IF & ~w_reset;

  // A flush discards the word returning this cycle along with everything queued.
  assign w_push = r_req_v & ~flush_i_IF & ~w_reset;

  assign pc_hold_o_IF    = w_hold;
  assign rom_ce_o_IF     = w_issue;
  assign rom_addr_o_IF   = w_issue ? pc_addr_i_IF : '0;
  assign inst_valid_o_IF = w_valid;
  assign inst_o_IF       = w_valid ? w_head[DATA_W-1:0] : DATA_W'(NOP_INST);
  assign inst_addr_o_IF  = w_valid ? w_head[ENT_W-1:DATA_W] : '0;

  // w_issue is already low under flush and reset, so the in-flight flag
  // clears in those cycles without a separate branch.
  always_ff @(posedge clk_i_IF) begin
    if (w_reset) begin
      r_req_v  <= 1'b0;
      r_req_pc <= '0;
    end else begin
      r_req_v <= w_issue;
      if (w_issue) r_req_pc <= pc_addr_i_IF;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .i_clk      (clk_i_IF),
    .i_reset    (reset_i_IF),
    .i_push     (w_push),
    .i_push_dat ({r_req_pc, rom_data_i_IF}),
    .i_pop      (w_pop),
    .i_flush    (flush_i_IF),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // The hold rule reserves a slot for every read in flight.
  a_no_push_when_full : assert property (@(posedge clk_i_IF) disable iff (w_reset)
    !(w_push && w_full));

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose: self-checking bench for instr_fetch against a queue-based reference.
// Latency: one step per clock; outputs compared at the falling edge.
// Backpressure: decode ready is driven by directed phases and then randomly.
module tb_instr_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        en;
  logic        hold;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        flush;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        ready;

  instr_fetch #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i_IF         (clk),
    .reset_i_IF       (rst),
    .pc_addr_i_IF     (pc),
    .chip_enable_i_IF (en),
    .pc_hold_o_IF     (hold),
    .rom_ce_o_IF      (rom_ce),
    .rom_addr_o_IF    (rom_addr),
    .rom_data_i_IF    (rom_data),
    .flush_i_IF       (flush),
    .inst_valid_o_IF  (valid),
    .inst_o_IF        (inst),
    .inst_addr_o_IF   (inst_addr),
    .inst_ready_i_IF  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the buffered pairs in order, plus the one read the ROM is serving.
  ent_t        mq[$];
  bit          m_inflight = 0;
  logic [31:0] m_inflight_pc = '0;

  // Directed-phase observations.
  int          cyc = 0;
  bit          track_thru = 0;
  int          thru_holds = 0;
  int          t_issue = -1;
  int          t_valid = -1;
  bit          track_deliv = 0;
  logic [31:0] deliv[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: apply inputs, compare outputs before the edge, then advance the
  // reference and the ROM. The PC advances only when a read was issued.
  task automatic step(input bit r, input bit e, input bit f, input bit rdy);
    bit          e_valid, e_pop, e_hold, e_ce;
    logic [31:0] e_inst, e_iaddr, e_raddr;
    bit          got_ce;
    logic [31:0] got_addr;
    int          occ;
    rst = r; en = e; flush = f; ready = rdy;
    @(negedge clk);
    e_valid = !r && (mq.size() > 0);
    e_inst  = e_valid ? mq[0].d : NOP;
    e_iaddr = e_valid ? mq[0].a : 32'h0;
    e_pop   = e_valid && rdy;
    occ     = mq.size() - (e_pop ? 1 : 0) + (m_inflight ? 1 : 0);
    e_hold  = !r && (occ >= DEPTH);
    e_ce    = e && !e_hold && !f && !r;
    e_raddr = e_ce ? pc : 32'h0;
    check("valid",    64'(valid),     64'(e_valid));
    check("inst",     64'(inst),      64'(e_inst));
    check("iaddr",    64'(inst_addr), 64'(e_iaddr));
    check("hold",     64'(hold),      64'(e_hold));
    check("rom_ce",   64'(rom_ce),    64'(e_ce));
    check("rom_addr", 64'(rom_addr),  64'(e_raddr));
    got_ce   = rom_ce;
    got_addr = rom_addr;
    if (track_thru && hold) thru_holds++;
    if (track_thru && t_issue < 0 && rom_ce) t_issue = cyc;
    if (track_thru && t_valid < 0 && valid)  t_valid = cyc;
    if (track_deliv && valid && rdy) deliv.push_back(inst_addr);
    @(posedge clk);
    #1;
    cyc++;
    if (r || f) begin
      mq.delete();
      m_inflight = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_inflight) mq.push_back('{a: m_inflight_pc, d: m_inflight_pc << 2});
      m_inflight    = e_ce;
      m_inflight_pc = pc;
    end
    // The ROM answers whatever the DUT actually requested; idle cycles carry junk.
    rom_data = got_ce ? (got_addr << 2) : $urandom();
    if (e_ce) pc = pc + 32'd1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; ready = 1'b0;
    pc = 32'h0; rom_data = 32'h0;

    // Reset with activity on the inputs: outputs must stay idle.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1);

    // Streaming, decode always ready: 2-cycle latency, no hold.
    pc = 32'h0;
    track_thru = 1;
    for (int i = 0; i < 12; i++) step(0, 1, 0, 1);
    track_thru = 0;
    check("thru_hold_cycles", 64'(thru_holds), 64'(0));
    check("first_latency",    64'(t_valid - t_issue), 64'(2));

    // Decode stall then resume.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1);

    // Flush with a full buffer, then with a read in flight while streaming.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    pc = 32'd100;
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    pc = 32'd200;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1);

    // Chip-enable bubble among 4, 5, 6.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    pc = 32'd4;
    track_deliv = 1;
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    track_deliv = 0;
    check("bubble_count", 64'(deliv.size()), 64'(3));
    if (deliv.size() == 3) begin
      check("bubble_0", 64'(deliv[0]), 64'(4));
      check("bubble_1", 64'(deliv[1]), 64'(5));
      check("bubble_2", 64'(deliv[2]), 64'(6));
    end

    // Reset while full with decode ready, then a clean restart.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    pc = 32'd300;
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1);

    // Random traffic.
    for (int i = 0; i < 9000; i++) begin
      bit r, e, f, rdy;
      r   = ($urandom_range(0, 199) == 0);
      f   = ($urandom_range(0, 31) == 0);
      e   = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      step(r, e, f, rdy);
      if (r || f) pc = $urandom_range(0, 65535);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
